// File: rtl/alu_op_sequencer_if.sv
// Handshake/bus bundle between alu_op_sequencer and its environment
// (upstream op source, the registered ALU, downstream result sink).
// slave  : the sequencer side.
// master : the environment side (drives ops, ALU result and res_ready).
interface alu_op_sequencer_if #(
    parameter int AW = 2
);
    // upstream operation channel
    logic          op_valid;
    logic          op_ready;
    logic [7:0]    op_a;
    logic [7:0]    op_b;
    logic [2:0]    op_func;
    logic          op_chain;
    // ALU drive / return
    logic [7:0]    alu_in1;
    logic [7:0]    alu_in2;
    logic [2:0]    alu_func;
    logic [7:0]    alu_out;
    // downstream result channel
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic [2:0]    res_func;
    // status
    logic [AW:0]   count;
    logic          busy;

    modport slave (
        input  op_valid, op_a, op_b, op_func, op_chain, alu_out, res_ready,
        output op_ready, alu_in1, alu_in2, alu_func,
               res_valid, res_data, res_func, count, busy
    );

    modport master (
        output op_valid, op_a, op_b, op_func, op_chain, alu_out, res_ready,
        input  op_ready, alu_in1, alu_in2, alu_func,
               res_valid, res_data, res_func, count, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU operations in a DEPTH-entry FIFO, issues
// them one at a time to an external registered ALU, captures each result
// and holds it on a valid/ready output until accepted.
// Optional feature macro: ALU_SEQ_CHAIN_EN -- an entry with op_chain set
// takes ALU in1 from the previously captured result instead of op_a.
module alu_op_sequencer #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // FIFO storage and bookkeeping
    logic [7:0]    r_fifo_a    [DEPTH];
    logic [7:0]    r_fifo_b    [DEPTH];
    logic [2:0]    r_fifo_func [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // FSM and output registers
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_alu_in1;
    logic [7:0]    r_alu_in2;
    logic [2:0]    r_alu_func;
    logic [2:0]    r_pend_func;
    logic          r_res_valid;
    logic [7:0]    r_res_data;
    logic [2:0]    r_res_func;

    logic          w_op_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_capt;
    logic          w_res_clr;
    logic          w_fifo_nempty;
    logic [7:0]    w_head_in1;

    // op_ready depends on registered occupancy only; held low during reset
    assign w_op_ready    = rst_n && (r_count != FULL_CNT);
    assign w_push        = bus.op_valid && w_op_ready;
    assign w_fifo_nempty = (r_count != '0);

`ifdef ALU_SEQ_CHAIN_EN
    logic          r_fifo_chain [DEPTH];
    logic [7:0]    r_last_res;

    // chained entries reuse the most recent captured result as in1
    assign w_head_in1 = r_fifo_chain[r_rd_ptr] ? r_last_res : r_fifo_a[r_rd_ptr];

    // chain flag storage, written alongside the operand entry
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_chain[r_wr_ptr] <= bus.op_chain;
    end

    // last captured result, source for chained operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_last_res <= '0;
        else if (w_capt) r_last_res <= bus.alu_out;
    end
`else
    logic w_unused_chain;
    assign w_unused_chain = bus.op_chain;
    assign w_head_in1     = r_fifo_a[r_rd_ptr];
`endif

    // FIFO payload write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]    <= bus.op_a;
            r_fifo_b[r_wr_ptr]    <= bus.op_b;
            r_fifo_func[r_wr_ptr] <= bus.op_func;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: IDLE -> EXEC -> CAPT -> HOLD -> (EXEC | IDLE)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fifo_nempty) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.res_ready) w_state_nxt = w_fifo_nempty ? S_EXEC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: pop/load strobe, result capture, result release
    always_comb begin
        w_pop     = 1'b0;
        w_capt    = 1'b0;
        w_res_clr = 1'b0;
        case (r_state)
            S_IDLE: w_pop = w_fifo_nempty;
            S_CAPT: w_capt = 1'b1;
            S_HOLD: begin
                if (bus.res_ready) begin
                    w_res_clr = 1'b1;
                    w_pop     = w_fifo_nempty;
                end
            end
            default: ;
        endcase
    end

    // ALU drive registers load on every pop and otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_alu_func  <= '0;
            r_pend_func <= '0;
        end else if (w_pop) begin
            r_alu_in1   <= w_head_in1;
            r_alu_in2   <= r_fifo_b[r_rd_ptr];
            r_alu_func  <= r_fifo_func[r_rd_ptr];
            r_pend_func <= r_fifo_func[r_rd_ptr];
        end
    end

    // result register: capture in CAPT, hold until the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_func  <= '0;
        end else if (w_capt) begin
            r_res_valid <= 1'b1;
            r_res_data  <= bus.alu_out;
            r_res_func  <= r_pend_func;
        end else if (w_res_clr) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.op_ready  = w_op_ready;
    assign bus.alu_in1   = r_alu_in1;
    assign bus.alu_in2   = r_alu_in2;
    assign bus.alu_func  = r_alu_func;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_func  = r_res_func;
    assign bus.count     = r_count;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural registered ALU.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_op_sequencer_if #(.AW(AW)) bus ();

    alu_op_sequencer #(.DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // registered ALU: 000 ADD 001 SUB 010 NOT 011 AND 100 XOR 101 SHL 110 SHR 111 OR
    function automatic logic [7:0] alu_f(input logic [7:0] x, y, input logic [2:0] f);
        case (f)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return ~x;
            3'd3: return x & y;
            3'd4: return x ^ y;
            3'd5: return x << 1;
            3'd6: return x >> 1;
            default: return x | y;
        endcase
    endfunction

    always @(posedge clk) bus.alu_out <= alu_f(bus.alu_in1, bus.alu_in2, bus.alu_func);

    // result monitor: every accepted result with the cycle of its handshake
    typedef struct {
        logic [7:0] d;
        logic [2:0] f;
        int         c;
    } res_t;
    res_t rq[$];

    always @(posedge clk)
        if (rst_n && bus.res_valid && bus.res_ready) rq.push_back('{bus.res_data, bus.res_func, cyc});

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic issue(input logic [7:0] a, b, input logic [2:0] f, input logic ch);
        int n = 0;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_a = a; bus.op_b = b; bus.op_func = f; bus.op_chain = ch;
        while (!bus.op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.op_ready) timeout("issue_wait");
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string nm);
        int k = 0;
        while (rq.size() < n && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        if (rq.size() < n) timeout(nm);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] f;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [7:0] held;
        int         acc;
        logic [7:0] exp2;

        vecs[0] = '{8'd200, 8'd100, 3'b000, 8'd44};
        vecs[1] = '{8'd5,   8'd7,   3'b001, 8'hFE};
        vecs[2] = '{8'd5,   8'd0,   3'b010, 8'd250};
        vecs[3] = '{8'd255, 8'd1,   3'b000, 8'd0};
        vecs[4] = '{8'hA5,  8'h0F,  3'b111, 8'hAF};
        vecs[5] = '{8'd0,   8'd1,   3'b001, 8'hFF};

        bus.op_valid = 0; bus.op_a = 0; bus.op_b = 0; bus.op_func = 0; bus.op_chain = 0;
        bus.res_ready = 0;

        // reset state
        #1;
        check("rst_op_ready", {31'd0, bus.op_ready}, 0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 0);
        check("rst_count", 32'(bus.count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_op_ready", {31'd0, bus.op_ready}, 1);
        check("rel_busy", {31'd0, bus.busy}, 0);

        // single ops, res_ready high: latency and pass-through
        bus.res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rq.delete();
            issue(vecs[i].a, vecs[i].b, vecs[i].f, 1'b0);
            @(posedge clk); #1;
            check($sformatf("v%0d_in1", i), 32'(bus.alu_in1), 32'(vecs[i].a));
            check($sformatf("v%0d_in2", i), 32'(bus.alu_in2), 32'(vecs[i].b));
            check($sformatf("v%0d_E1_valid", i), {31'd0, bus.res_valid}, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_E2_valid", i), {31'd0, bus.res_valid}, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_E3_valid", i), {31'd0, bus.res_valid}, 1);
            check($sformatf("v%0d_data", i), 32'(bus.res_data), 32'(vecs[i].exp));
            check($sformatf("v%0d_func", i), 32'(bus.res_func), 32'(vecs[i].f));
            @(posedge clk); #1;
            check($sformatf("v%0d_clr", i), {31'd0, bus.res_valid}, 0);
            check($sformatf("v%0d_idle", i), {31'd0, bus.busy}, 0);
        end

        // back to back SUB then NOT: in order, 3 cycles apart
        rq.delete();
        issue(8'd5, 8'd7, 3'b001, 1'b0);
        issue(8'd5, 8'd0, 3'b010, 1'b0);
        wait_results(2, "b2b_wait");
        if (rq.size() >= 2) begin
            check("b2b_r0", 32'(rq[0].d), 32'hFE);
            check("b2b_r1", 32'(rq[1].d), 32'd250);
            check("b2b_gap", 32'(rq[1].c - rq[0].c), 3);
        end

        // blocked output: DEPTH+1 accepted, then in-order drain
        rq.delete();
        bus.res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.op_valid = 1'b1; bus.op_a = 8'(i * 10); bus.op_b = 8'd1; bus.op_func = 3'b000;
            if (bus.op_ready) acc++;
            @(posedge clk);
        end
        #1 bus.op_valid = 1'b0;
        check("blk_accepted", 32'(acc), 5);
        check("blk_op_ready", {31'd0, bus.op_ready}, 0);
        check("blk_count", 32'(bus.count), 4);
        repeat (3) @(posedge clk);
        #1 held = bus.res_data;
        check("blk_valid", {31'd0, bus.res_valid}, 1);
        check("blk_first", 32'(held), 32'd1);
        repeat (4) @(posedge clk);
        #1 check("blk_stable", 32'(bus.res_data), 32'(held));
        @(negedge clk) bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check("blk_ready_back", {31'd0, bus.op_ready}, 1);
        check("blk_count3", 32'(bus.count), 3);
        wait_results(5, "blk_drain");
        if (rq.size() >= 5)
            for (int k = 0; k < 5; k++) check($sformatf("blk_r%0d", k), 32'(rq[k].d), 32'(k * 10 + 1));

        // push coinciding with pop in HOLD
        rq.delete();
        bus.res_ready = 1'b0;
        issue(8'd1, 8'd2, 3'b000, 1'b0);
        issue(8'd4, 8'd5, 3'b000, 1'b0);
        acc = 0;
        while (!bus.res_valid && acc < 20) begin
            @(posedge clk); #1;
            acc++;
        end
        if (!bus.res_valid) timeout("co_hold_wait");
        check("co_count_before", 32'(bus.count), 1);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_a = 8'd7; bus.op_b = 8'd8; bus.op_func = 3'b000;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        check("co_count_after", 32'(bus.count), 1);
        wait_results(3, "co_drain");
        repeat (6) @(posedge clk);
        #1 check("co_nres", 32'(rq.size()), 3);
        if (rq.size() >= 3) begin
            check("co_r0", 32'(rq[0].d), 32'd3);
            check("co_r1", 32'(rq[1].d), 32'd9);
            check("co_r2", 32'(rq[2].d), 32'd15);
        end

        // chained operand
`ifdef ALU_SEQ_CHAIN_EN
        exp2 = 8'd17;
`else
        exp2 = 8'd10;
`endif
        rq.delete();
        issue(8'd3, 8'd4, 3'b000, 1'b0);
        issue(8'd0, 8'd10, 3'b000, 1'b1);
        wait_results(2, "chain_wait");
        if (rq.size() >= 2) begin
            check("chain_r0", 32'(rq[0].d), 32'd7);
            check("chain_r1", 32'(rq[1].d), 32'(exp2));
        end

        // reset during EXEC
        rq.delete();
        issue(8'd9, 8'd9, 3'b000, 1'b0);
        @(posedge clk); #1;
        check("exec_busy", {31'd0, bus.busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_res_valid", {31'd0, bus.res_valid}, 0);
        check("ar_busy", {31'd0, bus.busy}, 0);
        check("ar_count", 32'(bus.count), 0);
        check("ar_op_ready", {31'd0, bus.op_ready}, 0);
        check("ar_alu", {13'd0, bus.alu_in1, bus.alu_in2, bus.alu_func}, 0);
        check("ar_res", {21'd0, bus.res_data, bus.res_func}, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ar_rel_ready", {31'd0, bus.op_ready}, 1);
        repeat (8) @(posedge clk);
        #1;
        check("ar_no_result", 32'(rq.size()), 0);
        check("ar_no_valid", {31'd0, bus.res_valid}, 0);
        issue(8'd1, 8'd1, 3'b000, 1'b0);
        wait_results(1, "ar_new_wait");
        if (rq.size() >= 1) check("ar_new", 32'(rq[0].d), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
